// File: rtl/mc_control.sv
// Multicycle datapath controller: FSM with a memory-wait watchdog and sticky HALT.
// Optional macro MC_CTRL_ADDI_EN adds the addi (001000) execute/writeback states.
module mc_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [7:0] WAIT_MAX   = 8'(MEM_WAIT_MAX);
    localparam bit         TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
`ifdef MC_CTRL_ADDI_EN
        ,
        S_ADDIEX,
        S_ADDIWB
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     cur;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       in_wait;
    logic       timeout;
    logic       mr_eff;
    logic       pc_uncond;
    logic       branch;

    // Cycles already spent stalled in the current memory-wait state.
    assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout = TIMEOUT_EN && in_wait && !mem_ready && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = S_ADDIEX;
`endif
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_HALT;
            end
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_HALT;
            end
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
`endif
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase

        // Count only while stalling in place; any move restarts the count at zero.
        wait_nxt = '0;
        if (in_wait && !mem_ready && (state_nxt == state)) begin
            wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
    end

    // While rst is high the outputs already show an idle FETCH cycle.
    assign cur    = rst ? S_FETCH : state;
    assign mr_eff = mem_ready && !rst;

    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        pc_uncond = 1'b0;
        branch    = 1'b0;
        err       = 1'b0;
        case (cur)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = mr_eff;
                pc_uncond = mr_eff;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: err = 1'b0;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI: err = 1'b0;
`endif
                    default: err = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                pc_uncond = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
`endif
            S_HALT:  err = 1'b1;
            default: err = 1'b0;
        endcase
    end

    assign PCWrite = pc_uncond | (branch & zero);

endmodule

// File: tb/tb_mc_control.sv
// Randomized and directed bench for mc_control, checked against an instruction-level model.
// Honours MC_CTRL_ADDI_EN the same way the design does.
module tb_mc_control;

    localparam int unsigned WAIT_MAX = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, err;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;

    mc_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Control word: {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,err}
    logic [14:0] dut_cw;
    assign dut_cw = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSrc, err};

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {
        PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
        PH_EXEC, PH_ALUWB, PH_BRANCH, PH_JUMP, PH_ADDIEX, PH_ADDIWB, PH_HALT
    } phase_t;

    phase_t m_ph = PH_FETCH;
    phase_t m_seq[$];
    int     m_wait = 0;

    function automatic logic legal(input logic [5:0] o);
        logic ok;
        ok = (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) || (o == OP_BEQ) || (o == OP_J);
`ifdef MC_CTRL_ADDI_EN
        ok = ok || (o == OP_ADDI);
`endif
        return ok;
    endfunction

    function automatic logic [14:0] cw(input logic pcw, input logic iord, input logic mw,
                                       input logic irw, input logic rdst, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc,
                                       input logic e);
        return {pcw, iord, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc, e};
    endfunction

    function automatic logic [14:0] expect_cw(input phase_t ph, input logic [5:0] o,
                                              input logic z, input logic mr);
        case (ph)
            PH_FETCH:  return cw(mr, 0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            PH_DECODE: return cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, !legal(o));
            PH_MEMADR: return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            PH_MEMRD:  return cw(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            PH_MEMWB:  return cw(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            PH_MEMWR:  return cw(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            PH_EXEC:   return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
            PH_ALUWB:  return cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            PH_BRANCH: return cw(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            PH_JUMP:   return cw(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
            PH_ADDIEX: return cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            PH_ADDIWB: return cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            default:   return cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
        endcase
    endfunction

    // Compare on every falling edge, then advance the model to the next cycle's phase.
    initial begin : compare
        logic [14:0] exp;
        forever begin
            @(negedge clk);
            exp = expect_cw(rst ? PH_FETCH : m_ph, op, zero, mem_ready && !rst);
            check($sformatf("ctrl_%s", rst ? "RESET" : m_ph.name()), 32'(dut_cw), 32'(exp));
            if (rst) begin
                m_ph   = PH_FETCH;
                m_wait = 0;
                m_seq.delete();
            end else if (m_ph == PH_HALT) begin
                m_ph = PH_HALT;
            end else if ((m_ph == PH_FETCH || m_ph == PH_MEMRD || m_ph == PH_MEMWR) && !mem_ready) begin
                if (WAIT_MAX != 0 && m_wait == int'(WAIT_MAX)) begin
                    m_ph   = PH_HALT;
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (m_ph == PH_FETCH) begin
                    m_ph = PH_DECODE;
                end else begin
                    if (m_ph == PH_DECODE) begin
                        m_seq.delete();
                        if (op == OP_LW) begin
                            m_seq.push_back(PH_MEMADR); m_seq.push_back(PH_MEMRD); m_seq.push_back(PH_MEMWB);
                        end else if (op == OP_SW) begin
                            m_seq.push_back(PH_MEMADR); m_seq.push_back(PH_MEMWR);
                        end else if (op == OP_RTYPE) begin
                            m_seq.push_back(PH_EXEC); m_seq.push_back(PH_ALUWB);
                        end else if (op == OP_BEQ) begin
                            m_seq.push_back(PH_BRANCH);
                        end else if (op == OP_J) begin
                            m_seq.push_back(PH_JUMP);
                        end else if (legal(op)) begin
                            m_seq.push_back(PH_ADDIEX); m_seq.push_back(PH_ADDIWB);
                        end
                    end
                    m_ph = (m_seq.size() != 0) ? m_seq.pop_front() : PH_FETCH;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [14:0] obs;

    // One clock cycle: drive inputs just after the rising edge, sample outputs mid-cycle.
    task automatic cyc(input logic [5:0] o, input logic z, input logic mr, input logic r);
        op        = o;
        zero      = z;
        mem_ready = mr;
        rst       = r;
        #2;
        obs = dut_cw;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [4:0] rw_mask;
        logic [6:0] mw_mask;
        int         pcw_cnt;
        int         err_cnt;
        int         first_err;
        logic [5:0] cur_op;

        @(posedge clk);
        #1;

        // Reset and the idle cycle right after it
        cyc(OP_RTYPE, 0, 0, 1);
        check("reset_outputs", 32'(obs), 32'h0020);
        cyc(OP_RTYPE, 0, 0, 0);
        check("after_reset_outputs", 32'(obs), 32'h0020);

        // lw with memory always ready: five cycles, one register write, one PC write
        cyc(OP_RTYPE, 0, 0, 1);
        rw_mask = '0;
        pcw_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(OP_LW, 0, 1, 0);
            rw_mask[i] = obs[8];
            pcw_cnt += int'(obs[14]);
        end
        check("lw_regwrite_only_memwb", 32'(rw_mask), 32'h10);
        check("lw_pcwrite_pulses", 32'(pcw_cnt), 32'd1);
        cyc(OP_LW, 0, 0, 0);
        check("lw_back_to_fetch", 32'(obs), 32'h0020);

        // beq taken, then not taken
        cyc(OP_RTYPE, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(OP_BEQ, 1, 1, 0);
        check("beq_taken_pcwrite", 32'(obs[14]), 32'd1);
        check("beq_taken_pcsrc", 32'(obs[2:1]), 32'd1);
        for (int i = 0; i < 3; i++) cyc(OP_BEQ, 0, 1, 0);
        check("beq_not_taken_pcwrite", 32'(obs[14]), 32'd0);
        check("beq_not_taken_pcsrc", 32'(obs[2:1]), 32'd1);

        // sw with memory ready three cycles late
        cyc(OP_RTYPE, 0, 0, 1);
        mw_mask = '0;
        for (int i = 0; i < 7; i++) begin
            cyc(OP_SW, 0, (i < 3 || i == 6), 0);
            mw_mask[i] = obs[12];
        end
        check("sw_memwrite_window", 32'(mw_mask), 32'h78);
        cyc(OP_SW, 0, 0, 0);
        check("sw_then_fetch", 32'(obs), 32'h0020);

        // Illegal opcode: single err pulse in decode, nothing written
        cyc(OP_RTYPE, 0, 0, 1);
        err_cnt = 0;
        cyc(OP_BAD, 0, 1, 0);
        err_cnt += int'(obs[0]);
        cyc(OP_BAD, 0, 1, 0);
        err_cnt += int'(obs[0]);
        check("illegal_decode", 32'(obs), 32'h0061);
        cyc(OP_BAD, 0, 0, 0);
        err_cnt += int'(obs[0]);
        check("illegal_back_to_fetch", 32'(obs), 32'h0020);
        check("illegal_err_cycles", 32'(err_cnt), 32'd1);

        // Watchdog: five stalled FETCH cycles then sticky HALT
        cyc(OP_RTYPE, 0, 0, 1);
        first_err = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(OP_RTYPE, 0, 0, 0);
            if (obs[0] && first_err == 0) first_err = i;
        end
        check("timeout_fetch_cycles", 32'(first_err), 32'd6);
        cyc(OP_J, 1, 1, 0);
        check("halt_sticky", 32'(obs), 32'h0001);
        cyc(OP_RTYPE, 0, 0, 1);
        check("halt_reset_outputs", 32'(obs), 32'h0020);
        cyc(OP_RTYPE, 0, 0, 0);
        check("halt_cleared", 32'(obs), 32'h0020);

        // Reset in the middle of a MEMRD stall restarts the wait count
        cyc(OP_RTYPE, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(OP_LW, 0, 1, 0);
        cyc(OP_LW, 0, 0, 0);
        cyc(OP_LW, 0, 0, 0);
        check("memrd_stall", 32'(obs), 32'h2000);
        cyc(OP_LW, 0, 0, 1);
        check("memrd_reset_outputs", 32'(obs), 32'h0020);
        first_err = 0;
        for (int i = 1; i <= 7; i++) begin
            cyc(OP_RTYPE, 0, 0, 0);
            if (obs[0] && first_err == 0) first_err = i;
        end
        check("reset_clears_wait", 32'(first_err), 32'd6);

        // addi: full sequence when enabled, illegal otherwise
        cyc(OP_RTYPE, 0, 0, 1);
        cyc(OP_ADDI, 0, 1, 0);
        cyc(OP_ADDI, 0, 1, 0);
`ifdef MC_CTRL_ADDI_EN
        check("addi_decode", 32'(obs), 32'h0060);
        cyc(OP_ADDI, 0, 1, 0);
        check("addi_exec", 32'(obs), 32'h00C0);
        cyc(OP_ADDI, 0, 1, 0);
        check("addi_writeback", 32'(obs), 32'h0100);
`else
        check("addi_illegal", 32'(obs), 32'h0061);
`endif
        cyc(OP_ADDI, 0, 0, 0);
        check("addi_back_to_fetch", 32'(obs), 32'h0020);

        // Randomized traffic; the opcode only changes while fetching
        cyc(OP_RTYPE, 0, 0, 1);
        cur_op = OP_RTYPE;
        for (int i = 0; i < 3000; i++) begin
            if (m_ph == PH_FETCH) begin
                case ($urandom_range(0, 7))
                    0: cur_op = OP_LW;
                    1: cur_op = OP_SW;
                    2: cur_op = OP_RTYPE;
                    3: cur_op = OP_BEQ;
                    4: cur_op = OP_J;
                    5: cur_op = OP_ADDI;
                    6: cur_op = OP_BAD;
                    default: cur_op = 6'($urandom);
                endcase
            end
            cyc(cur_op, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, giving the maximum cycles spent waiting on mem_ready (range 0..255; 0 disables the timeout).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port op, input, 6, the opcode field of the instruction register.
REQ-005 SHALL have port zero, input, 1, the ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, the memory-access complete strobe.
REQ-007 SHALL have port PCWrite, output, 1, the PC register load enable, equal to pc_uncond OR (branch AND zero).
REQ-008 SHALL have outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite and ALUSrcA (1 bit each), and ALUSrcB, ALUOp and PCSrc (2 bits each): the standard multicycle datapath controls.
REQ-009 SHALL have port err, output, 1, which flags an illegal opcode or a memory timeout.

Function
REQ-010 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB and HALT.
REQ-011 SHALL drive all outputs from the current state only (Moore) except PCWrite, IRWrite, MemWrite and err, as stated below; unlisted outputs are 0 in every state.
REQ-012 In FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=1 and pc_uncond=1 only in a cycle with mem_ready=1; go to DECODE on mem_ready.
REQ-013 In DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; decode op as lw 100011 and sw 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX.
REQ-014 In DECODE, any other op SHALL pulse err for one cycle and return to FETCH.
REQ-015 In MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMRD for lw and MEMWR for sw.
REQ-016 In MEMRD: IorD=1; hold until mem_ready, then go to MEMWB.
REQ-017 In MEMWB: MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-018 In MEMWR: IorD=1, MemWrite=1 held until the mem_ready cycle inclusive, then go to FETCH.
REQ-019 In EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB; in ALUWB: RegDst=1, RegWrite=1, then go to FETCH.
REQ-020 In BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, branch=1, then go to FETCH.
REQ-021 In JUMP: PCSrc=10, pc_uncond=1, then go to FETCH.
REQ-022 SHALL keep a wait counter that clears on entry to FETCH, MEMRD or MEMWR and increments each cycle the block remains in one of those states with mem_ready=0.
REQ-023 When MEM_WAIT_MAX is nonzero and the wait counter equals MEM_WAIT_MAX with mem_ready=0, SHALL go to HALT; mem_ready=1 in that same cycle wins and completes normally.
REQ-024 HALT SHALL be sticky: all enables 0 and err=1 until rst.
REQ-025 PCWrite SHALL be asserted only in FETCH with mem_ready=1, in JUMP, or in BRANCH with zero=1.

Reset
REQ-026 rst=1 at a rising clk edge SHALL force FETCH, clear the wait counter and clear err, overriding any state including HALT and any in-progress wait.
REQ-027 During and directly after reset, SHALL drive all outputs to their FETCH values with mem_ready=0: PCWrite=0, IRWrite=0, MemWrite=0, RegWrite=0, err=0, ALUSrcB=01, and every other control 0.

Configuration
REQ-028 Macro MC_CTRL_ADDI_EN, when defined, SHALL enable op 001000: ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00) -> ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0) -> FETCH.
REQ-029 When MC_CTRL_ADDI_EN is undefined, ADDIEX and ADDIWB SHALL not exist and op 001000 SHALL be treated as illegal under REQ-014.

Verification
REQ-030 lw (100011), mem_ready=1 always -> FETCH, DECODE, MEMADR, MEMRD, MEMWB: 5 cycles, RegWrite=1 only in MEMWB, one PCWrite pulse.
REQ-031 beq (000100) with zero=1 -> PCWrite=1 and PCSrc=01 in BRANCH; with zero=0 -> PCWrite=0 throughout BRANCH.
REQ-032 sw with mem_ready delayed 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-033 MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> HALT entered after 5 FETCH cycles, err=1 sticky; rst=1 -> FETCH with err=0.
REQ-034 op=111111 -> err=1 for exactly one cycle in DECODE, next state FETCH, no RegWrite/MemWrite/PCWrite.
REQ-035 rst asserted mid-MEMRD wait -> next cycle in FETCH, wait counter 0; addi (001000) runs a 4-cycle sequence with the macro defined and raises err without it.
